// File: rtl/alu16_sequencer_pkg.sv
// Shared types for the 16-bit ALU sequencer.
// ALUOp encodings, FSM states and small op-class helpers.
package alu16_sequencer_pkg;

   localparam int BYTE_W = 8;
   localparam int WORD_W = 16;

   typedef enum logic [3:0] {
      ALU_AND  = 4'd0,
      ALU_XOR  = 4'd1,
      ALU_OR   = 4'd2,
      ALU_LSL  = 4'd3,
      ALU_LSR  = 4'd4,
      ALU_ADD  = 4'd5,
      ALU_SUB  = 4'd6,
      ALU_LT   = 4'd7,
      ALU_GT   = 4'd8,
      ALU_EQ   = 4'd9,
      ALU_PASS = 4'd15
   } alu_op_e;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PASS1,
      ST_PASS2,
      ST_DONE
   } seq_state_e;

   // Unused encodings all behave as "pass inA".
   function automatic alu_op_e norm_op(input logic [3:0] op);
      if (op <= 4'd9) return alu_op_e'(op);
      return ALU_PASS;
   endfunction

   function automatic logic is_cmp(input alu_op_e op);
      return (op == ALU_LT) || (op == ALU_GT) || (op == ALU_EQ);
   endfunction

   function automatic logic has_carry(input alu_op_e op);
      return (op == ALU_LSL) || (op == ALU_LSR) ||
             (op == ALU_ADD) || (op == ALU_SUB);
   endfunction

endpackage

// File: rtl/alu16_sequencer.sv
// Runs 16-bit ops on an external 8-bit ALU as two byte passes.
// Ports: clk, reset (sync, active-high); req_* valid/ready request
// (op, a, b, cin); rsp_* valid/ready response (rslt, carry, flag);
// alu_op/alu_inA/alu_inB/alu_cin to ALU; alu_rslt/alu_cout/alu_flag back.
module alu16_sequencer
   import alu16_sequencer_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_op,
   input  logic [15:0] req_a,
   input  logic [15:0] req_b,
   input  logic        req_cin,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rslt,
   output logic        rsp_carry,
   output logic        rsp_flag,
   output logic [3:0]  alu_op,
   output logic [7:0]  alu_inA,
   output logic [7:0]  alu_inB,
   output logic        alu_cin,
   input  logic [7:0]  alu_rslt,
   input  logic        alu_cout,
   input  logic        alu_flag
);

   seq_state_e  state_q, state_d;
   alu_op_e     op_q, op_d;
   logic [15:0] a_q, a_d;
   logic [15:0] b_q, b_d;
   logic [7:0]  byte_q, byte_d;

   logic [3:0]  alu_op_d;
   logic [7:0]  alu_ina_d, alu_inb_d;
   logic        alu_cin_d;

   logic        rsp_valid_d;
   logic [15:0] rsp_rslt_d;
   logic        rsp_carry_d, rsp_flag_d;

   alu_op_e     req_op_n;

   assign req_op_n  = norm_op(req_op);
   assign req_ready = (state_q == ST_IDLE);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         op_q      <= ALU_PASS;
         a_q       <= '0;
         b_q       <= '0;
         byte_q    <= '0;
         alu_op    <= 4'b1111;
         alu_inA   <= '0;
         alu_inB   <= '0;
         alu_cin   <= 1'b0;
         rsp_valid <= 1'b0;
         rsp_rslt  <= '0;
         rsp_carry <= 1'b0;
         rsp_flag  <= 1'b0;
      end else begin
         state_q   <= state_d;
         op_q      <= op_d;
         a_q       <= a_d;
         b_q       <= b_d;
         byte_q    <= byte_d;
         alu_op    <= alu_op_d;
         alu_inA   <= alu_ina_d;
         alu_inB   <= alu_inb_d;
         alu_cin   <= alu_cin_d;
         rsp_valid <= rsp_valid_d;
         rsp_rslt  <= rsp_rslt_d;
         rsp_carry <= rsp_carry_d;
         rsp_flag  <= rsp_flag_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      op_d        = op_q;
      a_d         = a_q;
      b_d         = b_q;
      byte_d      = byte_q;
      alu_op_d    = alu_op;
      alu_ina_d   = alu_inA;
      alu_inb_d   = alu_inB;
      alu_cin_d   = alu_cin;
      rsp_valid_d = rsp_valid;
      rsp_rslt_d  = rsp_rslt;
      rsp_carry_d = rsp_carry;
      rsp_flag_d  = rsp_flag;

      unique case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               state_d   = ST_PASS1;
               op_d      = req_op_n;
               a_d       = req_a;
               b_d       = req_b;
               // First pass: low bytes unless the op starts high.
               alu_op_d  = req_op_n;
               alu_ina_d = req_a[7:0];
               alu_inb_d = req_b[7:0];
               alu_cin_d = 1'b0;
               unique case (req_op_n)
                  ALU_SUB: begin
                     alu_op_d  = ALU_ADD;
                     alu_inb_d = ~req_b[7:0];
                     alu_cin_d = 1'b1;
                  end
                  ALU_LSL: alu_cin_d = req_cin;
                  ALU_LSR: begin
                     alu_ina_d = req_a[15:8];
                     alu_inb_d = req_b[15:8];
                     alu_cin_d = req_cin;
                  end
                  ALU_LT, ALU_GT, ALU_EQ: begin
                     // High-byte equality decides the deciding byte.
                     alu_op_d  = ALU_EQ;
                     alu_ina_d = req_a[15:8];
                     alu_inb_d = req_b[15:8];
                  end
                  default: ;
               endcase
            end
         end

         ST_PASS1: begin
            state_d   = ST_PASS2;
            byte_d    = alu_rslt;
            alu_op_d  = op_q;
            alu_ina_d = a_q[15:8];
            alu_inb_d = b_q[15:8];
            alu_cin_d = 1'b0;
            unique case (op_q)
               ALU_SUB: begin
                  alu_op_d  = ALU_ADD;
                  alu_inb_d = ~b_q[15:8];
                  alu_cin_d = alu_cout;
               end
               ALU_ADD, ALU_LSL: alu_cin_d = alu_cout;
               ALU_LSR: begin
                  alu_ina_d = a_q[7:0];
                  alu_inb_d = b_q[7:0];
                  alu_cin_d = alu_cout;
               end
               ALU_LT, ALU_GT, ALU_EQ: begin
                  if (alu_flag) begin
                     alu_ina_d = a_q[7:0];
                     alu_inb_d = b_q[7:0];
                  end
               end
               default: ;
            endcase
         end

         ST_PASS2: begin
            state_d     = ST_DONE;
            rsp_valid_d = 1'b1;
            rsp_rslt_d  = {alu_rslt, byte_q};
            rsp_carry_d = 1'b0;
            rsp_flag_d  = 1'b0;
            // LSR produced the high byte first.
            if (op_q == ALU_LSR) rsp_rslt_d = {byte_q, alu_rslt};
            if (has_carry(op_q)) rsp_carry_d = alu_cout;
            if (is_cmp(op_q)) begin
               rsp_rslt_d = '0;
               rsp_flag_d = alu_flag;
            end
            alu_op_d  = ALU_PASS;
            alu_ina_d = '0;
            alu_inb_d = '0;
            alu_cin_d = 1'b0;
         end

         ST_DONE: begin
            if (rsp_ready) begin
               state_d     = ST_IDLE;
               rsp_valid_d = 1'b0;
            end
         end
      endcase
   end

endmodule
